// File: rtl/video_timing.sv
// Raster timing generator: signed pixel/line coordinates, visible window flag, frame start pulse
// and hsync/vsync delayed to line up with the scan-out pixel stream.
module video_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int Y_BORDER   = 48,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int SYNC_DELAY = 4
) (
    input  logic               vClk,
    input  logic               reset,
    output logic signed [12:0] x,
    output logic signed [12:0] y,
    output logic               visible,
    output logic               frameStart,
    output logic               hsync,
    output logic               vsync
);

    localparam int HS_I = -(H_SYNC + H_BACK);
    localparam int HE_I = H_VISIBLE + H_FRONT - 1;
    localparam int VS_I = -(V_SYNC + V_BACK + Y_BORDER);
    localparam int VE_I = V_VISIBLE - Y_BORDER + V_FRONT - 1;

    localparam logic signed [12:0] HS       = 13'(HS_I);
    localparam logic signed [12:0] HE       = 13'(HE_I);
    localparam logic signed [12:0] VS       = 13'(VS_I);
    localparam logic signed [12:0] VE       = 13'(VE_I);
    localparam logic signed [12:0] X_END    = 13'(H_VISIBLE);
    localparam logic signed [12:0] Y_TOP    = 13'(-Y_BORDER);
    localparam logic signed [12:0] Y_END    = 13'(V_VISIBLE - Y_BORDER);
    localparam logic signed [12:0] HSYNC_END = 13'(HS_I + H_SYNC);
    localparam logic signed [12:0] VSYNC_END = 13'(VS_I + V_SYNC);

    logic signed [12:0] x_q, x_d;
    logic signed [12:0] y_q, y_d;
    logic               visible_q, visible_d;
    logic               frame_start_q, frame_start_d;
    logic               hs_raw_q, hs_raw_d;
    logic               vs_raw_q, vs_raw_d;

    // Everything below is derived from the next coordinates so flags stay aligned with x/y.
    always_comb begin
        x_d = x_q + 13'sd1;
        y_d = y_q;
        if (x_q == HE) begin
            x_d = HS;
            y_d = (y_q == VE) ? VS : y_q + 13'sd1;
        end
        visible_d     = (x_d >= 13'sd0) && (x_d < X_END) && (y_d >= Y_TOP) && (y_d < Y_END);
        frame_start_d = (x_d == HS) && (y_d == VS);
        hs_raw_d      = ((x_d >= HS) && (x_d < HSYNC_END)) ? H_POL : ~H_POL;
        vs_raw_d      = ((y_d >= VS) && (y_d < VSYNC_END)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge vClk or posedge reset) begin
        if (reset) begin
            x_q           <= HS;
            y_q           <= VS;
            visible_q     <= 1'b0;
            frame_start_q <= 1'b1;
            hs_raw_q      <= ~H_POL;
            vs_raw_q      <= ~V_POL;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            visible_q     <= visible_d;
            frame_start_q <= frame_start_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign visible    = visible_q;
    assign frameStart = frame_start_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync = hs_raw_q;
            assign vsync = vs_raw_q;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d    = hs_pipe_q;
                vs_pipe_d    = vs_pipe_q;
                hs_pipe_d[0] = hs_raw_q;
                vs_pipe_d[0] = vs_raw_q;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            always_ff @(posedge vClk or posedge reset) begin
                if (reset) begin
                    hs_pipe_q <= {SYNC_DELAY{~H_POL}};
                    vs_pipe_q <= {SYNC_DELAY{~V_POL}};
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hsync = hs_pipe_q[SYNC_DELAY-1];
            assign vsync = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default, no-delay/positive-hsync and shrunken-raster instances checked
// per cycle against a position-from-cycle-count model, plus checkpoint vectors and run counts.
module tb_video_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [12:0] d_x, d_y, v_x, v_y, s_x, s_y;
    logic d_vis, d_fs, d_hs, d_vs;
    logic v_vis, v_fs, v_hs, v_vs;
    logic s_vis, s_fs, s_hs, s_vs;

    video_timing u_dut (
        .vClk(clk), .reset(rst), .x(d_x), .y(d_y), .visible(d_vis), .frameStart(d_fs),
        .hsync(d_hs), .vsync(d_vs)
    );

    video_timing #(.SYNC_DELAY(0), .H_POL(1'b1)) u_var (
        .vClk(clk), .reset(rst), .x(v_x), .y(v_y), .visible(v_vis), .frameStart(v_fs),
        .hsync(v_hs), .vsync(v_vs)
    );

    video_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_VISIBLE(6), .V_FRONT(1),
        .V_SYNC(2), .V_BACK(1), .Y_BORDER(2), .SYNC_DELAY(2)
    ) u_small (
        .vClk(clk), .reset(rst), .x(s_x), .y(s_y), .visible(s_vis), .frameStart(s_fs),
        .hsync(s_hs), .vsync(s_vs)
    );

    typedef struct {
        int hv; int hf; int hsw; int hb; int vv; int vf; int vsw; int vb; int yb; int d;
        bit hp; bit vp;
    } cfg_t;
    typedef struct {int x; int y; bit vis; bit fs; bit hs; bit vs;} obs_t;
    typedef struct {int id; obs_t e;} sb_t;
    typedef struct {int id; int n; int x; int y; bit vis; bit fs;} vec_t;

    cfg_t cfg[3];
    sb_t  sbq[$];
    vec_t vt[20];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n = 0;
    bit   phase1 = 1'b1;

    int d_hs_low = 0, d_hs_first = 9999;
    int v_hs_high = 0, v_hs_first = 9999;
    int s_vis_cnt = 0, s_vs_low = 0, s_fs_cnt = 0;

    // Expected state n clocks after reset release, derived from raster position, not counters.
    function automatic obs_t model(cfg_t c, int cyc);
        obs_t o;
        int l, f, p, li, m;
        l = c.hsw + c.hb + c.hv + c.hf;
        f = c.vsw + c.vb + c.vv + c.vf;
        p = cyc % l;
        li = (cyc / l) % f;
        o.x = p - (c.hsw + c.hb);
        o.y = li - (c.vsw + c.vb + c.yb);
        o.vis = (o.x >= 0) && (o.x < c.hv) && (o.y >= -c.yb) && (o.y < c.vv - c.yb);
        o.fs = (p == 0) && (li == 0);
        o.hs = ~c.hp;
        o.vs = ~c.vp;
        m = cyc - c.d;
        if (m > 0) begin
            if ((m % l) < c.hsw) o.hs = c.hp;
            if (((m / l) % f) < c.vsw) o.vs = c.vp;
        end
        return o;
    endfunction

    function automatic obs_t sample(int id);
        obs_t o;
        case (id)
            0: o = '{int'(d_x), int'(d_y), d_vis, d_fs, d_hs, d_vs};
            1: o = '{int'(v_x), int'(v_y), v_vis, v_fs, v_hs, v_vs};
            default: o = '{int'(s_x), int'(s_y), s_vis, s_fs, s_hs, s_vs};
        endcase
        return o;
    endfunction

    task automatic check_int(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_obs(string name, obs_t got, obs_t exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d vis=%0b fs=%0b hs=%0b vs=%0b, expected x=%0d y=%0d vis=%0b fs=%0b hs=%0b vs=%0b",
                     name, got.x, got.y, got.vis, got.fs, got.hs, got.vs,
                     exp.x, exp.y, exp.vis, exp.fs, exp.hs, exp.vs);
        end
    endtask

    task automatic step();
        int   nn;
        sb_t  s;
        nn = rst ? 0 : n + 1;
        for (int id = 0; id < 3; id++) sbq.push_back('{id, model(cfg[id], nn)});
        @(posedge clk);
        #1;
        n = nn;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            check_obs($sformatf("sb%0d_n%0d", s.id, n), sample(s.id), s.e);
        end
        if (phase1 && n >= 800 && n < 1600) begin
            if (!d_hs) begin
                d_hs_low++;
                if (d_hs_first == 9999) d_hs_first = int'(d_x);
            end
            if (v_hs) begin
                v_hs_high++;
                if (v_hs_first == 9999) v_hs_first = int'(v_x);
            end
        end
        if (phase1 && n >= 150 && n < 300) begin
            if (s_vis) s_vis_cnt++;
            if (!s_vs) s_vs_low++;
            if (s_fs) s_fs_cnt++;
        end
    endtask

    task automatic check_reset_state(string tag);
        for (int id = 0; id < 3; id++)
            check_obs($sformatf("%s_dut%0d", tag, id), sample(id), model(cfg[id], 0));
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 48, 4, 1'b0, 1'b0};
        cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 48, 0, 1'b1, 1'b0};
        cfg[2] = '{8, 2, 3, 2, 6, 1, 2, 1, 2, 2, 1'b0, 1'b0};

        vt[0]  = '{0, 0, -144, -83, 1'b0, 1'b1};
        vt[1]  = '{2, 0, -5, -5, 1'b0, 1'b1};
        vt[2]  = '{0, 1, -143, -83, 1'b0, 1'b0};
        vt[3]  = '{2, 14, 9, -5, 1'b0, 1'b0};
        vt[4]  = '{2, 15, -5, -4, 1'b0, 1'b0};
        vt[5]  = '{2, 50, 0, -2, 1'b1, 1'b0};
        vt[6]  = '{2, 132, 7, 3, 1'b1, 1'b0};
        vt[7]  = '{2, 133, 8, 3, 1'b0, 1'b0};
        vt[8]  = '{2, 149, 9, 4, 1'b0, 1'b0};
        vt[9]  = '{2, 150, -5, -5, 1'b0, 1'b1};
        vt[10] = '{0, 799, 655, -83, 1'b0, 1'b0};
        vt[11] = '{0, 800, -144, -82, 1'b0, 1'b0};
        vt[12] = '{1, 800, -144, -82, 1'b0, 1'b0};
        vt[13] = '{0, 28143, -1, -48, 1'b0, 1'b0};
        vt[14] = '{0, 28144, 0, -48, 1'b1, 1'b0};
        vt[15] = '{0, 28783, 639, -48, 1'b1, 1'b0};
        vt[16] = '{0, 28784, 640, -48, 1'b0, 1'b0};
        vt[17] = '{0, 66543, -1, 0, 1'b0, 1'b0};
        vt[18] = '{0, 66544, 0, 0, 1'b1, 1'b0};
        vt[19] = '{0, 66844, 300, 0, 1'b1, 1'b0};

        #2 rst = 1'b1;
        #1 check_reset_state("por");
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            while (n < vt[i].n) step();
            begin
                obs_t o;
                o = sample(vt[i].id);
                check_int($sformatf("vec%0d_x", i), o.x, vt[i].x);
                check_int($sformatf("vec%0d_y", i), o.y, vt[i].y);
                check_int($sformatf("vec%0d_vis", i), int'(o.vis), int'(vt[i].vis));
                check_int($sformatf("vec%0d_fs", i), int'(o.fs), int'(vt[i].fs));
            end
        end

        check_int("hsync_low_len", d_hs_low, 96);
        check_int("hsync_low_first_x", d_hs_first, -140);
        check_int("var_hsync_high_len", v_hs_high, 96);
        check_int("var_hsync_first_x", v_hs_first, -144);
        check_int("small_visible_per_frame", s_vis_cnt, 48);
        check_int("small_vsync_low_per_frame", s_vs_low, 30);
        check_int("small_framestart_per_frame", s_fs_cnt, 1);

        // Mid-frame reset asserted between edges must take effect without a clock.
        phase1 = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        n = 0;
        repeat (3) step();
        rst = 1'b0;
        repeat (800) step();
        check_int("post_reset_line_x", int'(d_x), -144);
        check_int("post_reset_line_y", int'(d_y), -82);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
